nx_indirect_access_initiator: RTL and testbench

- Host-side sequencer driving the command/status register interface of an indirect access controller. It is the initiator; the controller is the responder.
- Accepts one request (op, addr, table_id, write data) over valid/ready, then issues a single-cycle command-register write strobe.
- Polls the controller's status code until completion or error, optionally acknowledges errors, and returns status plus read data over a valid/ready response channel.
- Sits between CSR/test-master logic and any indirect-access table.

---
 rtl/nx_ia_pkg.sv | 46 ++++
 rtl/nx_ia_poll_timer.sv | 26 ++
 rtl/nx_indirect_access_initiator.sv | 139 +++++++++++++
 tb/tb_nx_indirect_access_initiator.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_ia_pkg.sv
// Shared types for the indirect access initiator and controller: opcodes,
// status codes, initiator states and small status-classification helpers.
package nx_ia_pkg;

    typedef enum logic [3:0] {
        IA_NOP       = 4'h0,
        IA_SIM_TMO   = 4'h1,
        IA_DISABLE   = 4'h2,
        IA_ENABLE    = 4'h3,
        IA_READ      = 4'h4,
        IA_WRITE     = 4'h5,
        IA_INIT      = 4'h6,
        IA_ACK_ERROR = 4'hF
    } ia_operation_e;

    typedef enum logic [2:0] {
        IA_ST_RDY = 3'd0,
        IA_ST_BSY = 3'd1,
        IA_ST_TMO = 3'd2,
        IA_ST_OVR = 3'd3,
        IA_ST_NXM = 3'd4,
        IA_ST_UOP = 3'd5,
        IA_ST_PDN = 3'd7
    } ia_status_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        POLL     = 3'd2,
        ACK      = 3'd3,
        ACK_POLL = 3'd4,
        RESP     = 3'd5
    } ia_init_state_e;

    localparam logic [3:0] ACK_ERROR_OP = 4'hF;

    // Ready or powered-down both mean the controller has finished a command.
    function automatic logic ia_is_done(input logic [2:0] code);
        return (code == 3'(IA_ST_RDY)) || (code == 3'(IA_ST_PDN));
    endfunction

    function automatic logic ia_is_error(input logic [2:0] code);
        return (code >= 3'(IA_ST_TMO)) && (code <= 3'(IA_ST_UOP));
    endfunction

endpackage

// File: rtl/nx_ia_poll_timer.sv
// Clearable saturating poll counter; full_c flags the all-ones timeout value.
module nx_ia_poll_timer #(
    parameter int unsigned N_POLL_BITS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic full_c
);

    logic [N_POLL_BITS-1:0] count;

    assign full_c = &count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !full_c) begin
            count <= count + N_POLL_BITS'(1);
        end
    end

endmodule

// File: rtl/nx_indirect_access_initiator.sv
// Host-side sequencer: accepts one request, strobes the command register,
// polls controller status (acking errors if enabled) and returns a response.
module nx_indirect_access_initiator
    import nx_ia_pkg::*;
#(
    parameter int unsigned N_REG_ADDR_BITS = 11,
    parameter logic [N_REG_ADDR_BITS-1:0] CMND_ADDRESS = N_REG_ADDR_BITS'(11'h020),
    parameter int unsigned N_DATA_BITS     = 96,
    parameter int unsigned N_ADDR_BITS     = 9,
    parameter int unsigned N_TABLE_BITS    = 1,
    parameter int unsigned N_POLL_BITS     = 8,
    parameter bit          AUTO_ACK        = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [3:0]                 req_op,
    input  logic [N_ADDR_BITS-1:0]     req_addr,
    input  logic [N_TABLE_BITS-1:0]    req_table_id,
    input  logic [N_DATA_BITS-1:0]     req_wdat,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [2:0]                 rsp_status,
    output logic                       rsp_timeout,
    output logic [N_DATA_BITS-1:0]     rsp_rdat,
    output logic                       wr_stb,
    output logic [N_REG_ADDR_BITS-1:0] reg_addr,
    output logic [3:0]                 cmnd_op,
    output logic [N_ADDR_BITS-1:0]     cmnd_addr,
    output logic [N_TABLE_BITS-1:0]    cmnd_table_id,
    output logic [N_DATA_BITS-1:0]     wr_dat,
    input  logic [2:0]                 stat_code,
    input  logic [N_DATA_BITS-1:0]     rd_dat
);

    ia_init_state_e state;
    logic           timer_clr_c;
    logic           timer_en_c;
    logic           poll_full_c;

    // Counter restarts in the strobe cycles so each poll phase gets a full budget.
    assign timer_clr_c = (state == ISSUE) || (state == ACK);
    assign timer_en_c  = (state == POLL) || (state == ACK_POLL);

    nx_ia_poll_timer #(
        .N_POLL_BITS (N_POLL_BITS)
    ) u_poll_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr_c),
        .en     (timer_en_c),
        .full_c (poll_full_c)
    );

    // The cmnd_* and wr_dat registers double as the request holding registers;
    // wr_dat only reloads on acceptance so it stays stable through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_status    <= '0;
            rsp_timeout   <= 1'b0;
            rsp_rdat      <= '0;
            wr_stb        <= 1'b0;
            reg_addr      <= '0;
            cmnd_op       <= '0;
            cmnd_addr     <= '0;
            cmnd_table_id <= '0;
            wr_dat        <= '0;
        end else begin
            wr_stb <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state         <= ISSUE;
                        req_ready     <= 1'b0;
                        wr_stb        <= 1'b1;
                        reg_addr      <= CMND_ADDRESS;
                        cmnd_op       <= req_op;
                        cmnd_addr     <= req_addr;
                        cmnd_table_id <= req_table_id;
                        wr_dat        <= req_wdat;
                    end
                end
                ISSUE: begin
                    state <= POLL;
                end
                POLL: begin
                    if (ia_is_done(stat_code)) begin
                        rsp_rdat   <= rd_dat;
                        rsp_status <= stat_code;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else if (ia_is_error(stat_code) || poll_full_c) begin
                        rsp_status  <= stat_code;
                        rsp_timeout <= !ia_is_error(stat_code);
                        if (AUTO_ACK) begin
                            wr_stb   <= 1'b1;
                            reg_addr <= CMND_ADDRESS;
                            cmnd_op  <= ACK_ERROR_OP;
                            state    <= ACK;
                        end else begin
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                ACK: begin
                    state <= ACK_POLL;
                end
                ACK_POLL: begin
                    // Original error code is kept; only a second timeout is recorded.
                    if (ia_is_done(stat_code)) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (poll_full_c) begin
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        req_ready   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nx_indirect_access_initiator.sv
// Directed bench for the indirect access initiator; the bench plays the
// controller by driving stat_code/rd_dat and scores responses from a queue.
module tb_nx_indirect_access_initiator;
    import nx_ia_pkg::*;

    localparam int unsigned DW = 96;
    localparam int unsigned AW = 9;
    localparam int unsigned TW = 1;
    localparam int unsigned RW = 11;

    typedef struct {
        logic [2:0]    status;
        logic          timeout;
        logic          chk_rdat;
        logic [DW-1:0] rdat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [TW-1:0] req_table_id;
    logic [DW-1:0] req_wdat;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [2:0]    rsp_status;
    logic          rsp_timeout;
    logic [DW-1:0] rsp_rdat;
    logic          wr_stb;
    logic [RW-1:0] reg_addr;
    logic [3:0]    cmnd_op;
    logic [AW-1:0] cmnd_addr;
    logic [TW-1:0] cmnd_table_id;
    logic [DW-1:0] wr_dat;
    logic [2:0]    stat_code;
    logic [DW-1:0] rd_dat;

    int   vectors = 0;
    int   errors  = 0;
    int   cyc;
    exp_t sb[$];

    always #5 clk = ~clk;

    nx_indirect_access_initiator dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_table_id  (req_table_id),
        .req_wdat      (req_wdat),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_status    (rsp_status),
        .rsp_timeout   (rsp_timeout),
        .rsp_rdat      (rsp_rdat),
        .wr_stb        (wr_stb),
        .reg_addr      (reg_addr),
        .cmnd_op       (cmnd_op),
        .cmnd_addr     (cmnd_addr),
        .cmnd_table_id (cmnd_table_id),
        .wr_dat        (wr_dat),
        .stat_code     (stat_code),
        .rd_dat        (rd_dat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [3:0] op, input logic [AW-1:0] addr,
                            input logic [TW-1:0] tid, input logic [DW-1:0] wdat);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_wait", DW'(req_ready), DW'(1));
        req_valid    = 1'b1;
        req_op       = op;
        req_addr     = addr;
        req_table_id = tid;
        req_wdat     = wdat;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_stb(input int budget, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!wr_stb && cycles < budget);
        check("stb_wait", DW'(wr_stb), DW'(1));
    endtask

    task automatic score(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, DW'(sb.size() != 0), DW'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_status"}, DW'(rsp_status), DW'(e.status));
            check({tag, "_timeout"}, DW'(rsp_timeout), DW'(e.timeout));
            if (e.chk_rdat) check({tag, "_rdat"}, rsp_rdat, e.rdat);
        end
    endtask

    task automatic collect(input string tag, input int hold);
        int n = 0;
        while (!rsp_valid && n < 600) begin
            tick();
            n++;
        end
        check({tag, "_rsp_valid"}, DW'(rsp_valid), DW'(1));
        repeat (hold) begin
            tick();
            check({tag, "_rsp_hold"}, DW'(rsp_valid), DW'(1));
        end
        check({tag, "_busy_req_ready"}, DW'(req_ready), DW'(0));
        score(tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_rsp_done"}, DW'(rsp_valid), DW'(0));
        check({tag, "_idle_req_ready"}, DW'(req_ready), DW'(1));
        check({tag, "_tmo_clear"}, DW'(rsp_timeout), DW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_op       = '0;
        req_addr     = '0;
        req_table_id = '0;
        req_wdat     = '0;
        rsp_ready    = 1'b0;
        stat_code    = 3'd7;
        rd_dat       = '0;
        repeat (2) tick();
        check("rst_req_ready", DW'(req_ready), DW'(1));
        check("rst_wr_stb", DW'(wr_stb), DW'(0));
        check("rst_rsp_valid", DW'(rsp_valid), DW'(0));
        check("rst_reg_addr", DW'(reg_addr), DW'(0));
        check("rst_rsp_status", DW'(rsp_status), DW'(0));
        rst = 1'b0;
        tick();

        // ENABLE from powered-down completes with RDY
        sb.push_back('{status: 3'd0, timeout: 1'b0, chk_rdat: 1'b1, rdat: DW'(0)});
        send_req(4'd3, 9'd0, 1'b0, DW'(0));
        check("en_stb", DW'(wr_stb), DW'(1));
        check("en_reg_addr", DW'(reg_addr), DW'(11'h020));
        check("en_op", DW'(cmnd_op), DW'(3));
        check("en_req_ready_low", DW'(req_ready), DW'(0));
        stat_code = 3'd0;
        tick();
        check("en_stb_single", DW'(wr_stb), DW'(0));
        collect("en", 1);

        // WRITE: wr_dat held through busy polling and into RESP
        sb.push_back('{status: 3'd0, timeout: 1'b0, chk_rdat: 1'b1, rdat: DW'(0)});
        send_req(4'd5, 9'd5, 1'b0, DW'(96'hA5A5));
        check("wr_addr", DW'(cmnd_addr), DW'(5));
        check("wr_dat_issue", wr_dat, DW'(96'hA5A5));
        stat_code = 3'd1;
        repeat (3) begin
            tick();
            check("wr_dat_hold", wr_dat, DW'(96'hA5A5));
            check("wr_busy_no_rsp", DW'(rsp_valid), DW'(0));
            check("wr_busy_no_stb", DW'(wr_stb), DW'(0));
        end
        stat_code = 3'd0;
        tick();
        check("wr_dat_resp", wr_dat, DW'(96'hA5A5));
        collect("wr", 0);

        // READ: data captured on completion
        sb.push_back('{status: 3'd0, timeout: 1'b0, chk_rdat: 1'b1, rdat: DW'(96'h1234)});
        send_req(4'd4, 9'd7, 1'b0, DW'(0));
        check("rd_addr", DW'(cmnd_addr), DW'(7));
        stat_code = 3'd1;
        repeat (2) tick();
        stat_code = 3'd0;
        rd_dat    = DW'(96'h1234);
        collect("rd", 0);
        rd_dat = '0;

        // NXM error at the top entry triggers an ACK_ERROR strobe
        sb.push_back('{status: 3'd4, timeout: 1'b0, chk_rdat: 1'b0, rdat: DW'(0)});
        send_req(4'd4, 9'd511, 1'b1, DW'(0));
        check("nxm_addr", DW'(cmnd_addr), DW'(511));
        check("nxm_tid", DW'(cmnd_table_id), DW'(1));
        stat_code = 3'd4;
        wait_stb(10, cyc);
        check("nxm_ack_latency", DW'(cyc), DW'(2));
        check("nxm_ack_op", DW'(cmnd_op), DW'(4'hF));
        check("nxm_ack_addr", DW'(reg_addr), DW'(11'h020));
        stat_code = 3'd0;
        collect("nxm", 0);

        // Poll timeout while BSY: counter runs 0..255 then ACK follows
        sb.push_back('{status: 3'd1, timeout: 1'b1, chk_rdat: 1'b0, rdat: DW'(0)});
        send_req(4'd4, 9'd1, 1'b0, DW'(0));
        stat_code = 3'd1;
        wait_stb(400, cyc);
        check("tmo_ack_latency", DW'(cyc), DW'(257));
        check("tmo_ack_op", DW'(cmnd_op), DW'(4'hF));
        stat_code = 3'd0;
        collect("tmo", 0);

        // Second timeout in ACK_POLL: error code kept, timeout flagged
        sb.push_back('{status: 3'd4, timeout: 1'b1, chk_rdat: 1'b0, rdat: DW'(0)});
        send_req(4'd4, 9'd2, 1'b0, DW'(0));
        stat_code = 3'd4;
        wait_stb(10, cyc);
        check("acktmo_ack_op", DW'(cmnd_op), DW'(4'hF));
        collect("acktmo", 0);

        // NOP completes with the unchanged code; requests during RESP are held off
        stat_code = 3'd7;
        sb.push_back('{status: 3'd7, timeout: 1'b0, chk_rdat: 1'b1, rdat: DW'(0)});
        send_req(4'd0, 9'd0, 1'b0, DW'(0));
        repeat (2) tick();
        check("nop_rsp_valid", DW'(rsp_valid), DW'(1));
        req_valid = 1'b1;
        req_op    = 4'd4;
        req_addr  = 9'd3;
        repeat (2) begin
            tick();
            check("resp_no_accept", DW'(wr_stb), DW'(0));
            check("resp_req_ready", DW'(req_ready), DW'(0));
        end
        score("nop");
        sb.push_back('{status: 3'd0, timeout: 1'b0, chk_rdat: 1'b1, rdat: DW'(0)});
        stat_code = 3'd0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("b2b_rsp_done", DW'(rsp_valid), DW'(0));
        check("b2b_idle_ready", DW'(req_ready), DW'(1));
        check("b2b_not_yet", DW'(wr_stb), DW'(0));
        tick();
        req_valid = 1'b0;
        check("b2b_stb", DW'(wr_stb), DW'(1));
        check("b2b_addr", DW'(cmnd_addr), DW'(3));
        collect("b2b", 0);

        // Reset mid-transaction returns to IDLE without a strobe
        send_req(4'd5, 9'd8, 1'b0, DW'(96'hFF));
        stat_code = 3'd1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_req_ready", DW'(req_ready), DW'(1));
        check("mid_rst_stb", DW'(wr_stb), DW'(0));
        check("mid_rst_rsp_valid", DW'(rsp_valid), DW'(0));
        check("mid_rst_wr_dat", wr_dat, DW'(0));
        tick();
        check("mid_rst_stays_idle", DW'(wr_stb), DW'(0));
        check("sb_drained", DW'(sb.size()), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
